icache_fetch: RTL and testbench
===============================

Name: icache_fetch

Overview:
- Direct-mapped, read-only instruction cache between the fetch stage (PC/instruction side) and the shared multi-cycle main memory.
- Hits return the instruction combinationally in the same cycle.
- On a miss, it stalls fetch and refills an 8-word line with a pipelined read burst, then replays the lookup.
- Replaces the ideal single-cycle instruction memory.

Parameters:
- NUM_SETS, 64, number of lines. Power of 2. Index width IW = log2(NUM_SETS).
- WORDS_PER_LINE, 8, 16-bit words per line (fixed at 8; offset = addr[3:1]).
- MEM_LAT, 4, cycles from an accepted memory read to its mem_rvalid; used only by the bench model.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  fetch requests instruction at req_addr this cycle
- req_addr  in  16  byte PC; bit 0 ignored
- flush  in  1  invalidate all lines
- instr  out  16  instruction; valid when req_valid & ~stall
- stall  out  1  fetch must hold PC and IF/ID register
- mem_rd  out  1  read request to main memory
- mem_addr  out  16  word-aligned read address
- mem_gnt  in  1  memory accepts mem_rd this cycle
- mem_rvalid  in  1  returned read data valid
- mem_rdata  in  16  returned word, in request order

Behaviour:
- Address split:
  - offset = addr[3:1]
  - index = addr[4+IW-1:4]
  - tag = addr[15:4+IW] (6 bits at default)
- Storage:
  - valid[NUM_SETS] is async-reset to 0.
  - tag and data arrays are not reset.
- hit = valid[index] & (tag_arr[index] == tag). When hit, instr = data[index][offset] combinationally.
- States: IDLE, FILL, DONE.
- IDLE:
  - stall = req_valid & ~hit.
  - On req_valid & ~hit: latch miss_addr = {req_addr[15:4], 4'b0}, clear issue_cnt and recv_cnt, go to FILL.
- FILL:
  - stall = 1.
  - mem_rd = (issue_cnt < 8); mem_addr = miss_addr + 2*issue_cnt.
  - issue_cnt increments only on mem_rd & mem_gnt. A denied request holds mem_addr stable.
  - Each mem_rvalid writes mem_rdata into data[miss_index][recv_cnt] and increments recv_cnt.
  - Issue and receive may overlap in the same cycle.
  - When the 8th word is received: write tag_arr[miss_index] = miss_tag, set valid[miss_index] = 1, go to DONE.
- DONE:
  - stall = 1 for exactly one cycle, then go to IDLE.
  - The lookup in IDLE then hits; the missed instruction is delivered in the first IDLE cycle.
- Miss latency: miss cycle, then FILL (≥ 8 + MEM_LAT cycles with continuous grant), then DONE, then hit.
- Counters are 4 bits; issue_cnt saturates at 8.
- mem_rvalid while in IDLE/DONE: ignored.
- mem_rvalid beyond 8 words: not allowed; the bench flags it as an error.
- flush:
  - In IDLE/DONE, clears all valid bits at the clock edge. A same-cycle lookup still uses the pre-flush valid bits.
  - In FILL, clears all valid bits immediately. The in-flight fill completes and sets its own line valid, which is safe because instruction memory is read-only.
- req_addr changing while stall = 1: ignored. Fetch must hold the PC; the refill always targets miss_addr.
- req_valid = 0 in IDLE: stall = 0, no state change. instr is don't-care but must be driven (no X from uninitialised arrays).
- Reset (asserted at any time, including mid-FILL):
  - state = IDLE, counters = 0, all valid = 0.
  - mem_rd = 0, stall = 0.
  - Any memory responses still outstanding from the aborted burst are dropped. The memory model is reset together with the cache.
- Outputs at reset: stall 0, mem_rd 0, mem_addr 0, instr 0.

Test Plan:
- Cold miss:
  - Stimulus: after reset, req_valid = 1, req_addr = 0x0000, mem_gnt tied 1, memory word k = 0xA000 + k.
  - Required: stall = 1 immediately; mem_rd addresses 0x0000, 0x0002, …, 0x000E on consecutive cycles; 8 rvalids; DONE for one cycle; then instr = 0xA000 with stall = 0.
- Line hits:
  - Stimulus: after the cold miss, step req_addr through 0x0002 to 0x000E.
  - Required: instr = 0xA001 through 0xA007, one per cycle, stall = 0 throughout, mem_rd never asserted.
- Conflict miss:
  - Stimulus: req_addr = 0x0400 (same index 0, tag 1).
  - Required: miss and refill from base 0x0400. A following access to 0x0000 misses again because the line was evicted.
- Grant backpressure:
  - Stimulus: mem_gnt low on the cycles the 3rd and 4th requests are offered.
  - Required: mem_addr held at 0x0004 while denied; the fill still writes all 8 words in order.
  - Required: total stall cycles = 2 more than the fully granted case.
- Flush:
  - Flush in IDLE after filling line 0: the next access to 0x0000 misses.
  - Flush asserted mid-FILL of 0x0010: the fill completes and 0x0010 hits afterwards.
- Reset mid-fill:
  - Stimulus: assert rst_n = 0 after 3 words received, then release.
  - Required: mem_rd = 0 and stall = 0 while in reset. A re-access of the same address then performs a full 8-word refill.

Source files
------------

// File: rtl/icache_fetch.sv
// Direct-mapped, read-only instruction cache with an 8-word line refill.
// Hits return the instruction combinationally; a miss stalls fetch while a pipelined burst refills the line.
module icache_fetch #(
  parameter int NUM_SETS       = 64,
  parameter int WORDS_PER_LINE = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [15:0] req_addr,
  input  logic        flush,
  output logic [15:0] instr,
  output logic        stall,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata
);
  localparam int IW = $clog2(NUM_SETS);
  localparam int TW = 12 - IW;
  localparam logic [3:0] LINE_WORDS = 4'(WORDS_PER_LINE);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_DONE = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [3:0]          issue_cnt_q, issue_cnt_d;
  logic [3:0]          recv_cnt_q, recv_cnt_d;
  logic [11:0]         miss_line_q, miss_line_d;
  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [TW-1:0]       tag_arr [NUM_SETS];
  logic [15:0]         data_arr [NUM_SETS*WORDS_PER_LINE];

  logic [2:0]    req_off_s;
  logic [IW-1:0] req_index_s;
  logic [TW-1:0] req_tag_s;
  logic [IW-1:0] miss_index_s;
  logic [TW-1:0] miss_tag_s;
  logic          hit_s;
  logic          mem_rd_s;
  logic          data_we_s;
  logic          tag_we_s;
  logic          addr_unused_s;

  assign req_off_s     = req_addr[3:1];
  assign req_index_s   = req_addr[4+IW-1:4];
  assign req_tag_s     = req_addr[15:4+IW];
  assign miss_index_s  = miss_line_q[IW-1:0];
  assign miss_tag_s    = miss_line_q[11:IW];
  assign addr_unused_s = req_addr[0];

  // Invalid lines never hit, so uninitialised tag/data contents cannot reach instr.
  assign hit_s  = valid_q[req_index_s] && (tag_arr[req_index_s] == req_tag_s);
  assign instr  = hit_s ? data_arr[{req_index_s, req_off_s}] : 16'h0000;
  assign mem_rd = mem_rd_s;

  // Next-state, refill sequencing and stall/memory-request decode.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    miss_line_d = miss_line_q;
    stall       = 1'b0;
    mem_rd_s    = 1'b0;
    mem_addr    = 16'h0000;
    data_we_s   = 1'b0;
    tag_we_s    = 1'b0;
    // Flush only affects later lookups; a completing fill re-marks its own line below.
    if (flush) begin
      valid_d = '0;
    end else begin
      valid_d = valid_q;
    end
    case (state_q)
      S_IDLE: begin
        if (req_valid && !hit_s) begin
          stall       = 1'b1;
          miss_line_d = req_addr[15:4];
          issue_cnt_d = 4'd0;
          recv_cnt_d  = 4'd0;
          state_d     = S_FILL;
        end else begin
          stall = 1'b0;
        end
      end
      S_FILL: begin
        stall    = 1'b1;
        mem_rd_s = (issue_cnt_q < LINE_WORDS);
        mem_addr = {miss_line_q, issue_cnt_q[2:0], 1'b0};
        if (mem_rd_s && mem_gnt) begin
          issue_cnt_d = issue_cnt_q + 4'd1;
        end else begin
          issue_cnt_d = issue_cnt_q;
        end
        if (mem_rvalid) begin
          data_we_s  = 1'b1;
          recv_cnt_d = recv_cnt_q + 4'd1;
          if (recv_cnt_q == LINE_WORDS - 4'd1) begin
            tag_we_s              = 1'b1;
            valid_d[miss_index_s] = 1'b1;
            state_d               = S_DONE;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          recv_cnt_d = recv_cnt_q;
        end
      end
      S_DONE: begin
        stall   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state with asynchronous reset; an aborted fill simply restarts from IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      issue_cnt_q <= 4'd0;
      recv_cnt_q  <= 4'd0;
      miss_line_q <= 12'h000;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      miss_line_q <= miss_line_d;
      valid_q     <= valid_d;
    end
  end

  // Tag and data arrays carry no reset; words land in arrival order.
  always_ff @(posedge clk) begin
    if (data_we_s) begin
      data_arr[{miss_index_s, recv_cnt_q[2:0]}] <= mem_rdata;
    end
    if (tag_we_s) begin
      tag_arr[miss_index_s] <= miss_tag_s;
    end
  end

endmodule

// File: tb/tb_icache_fetch.sv
// Self-checking bench for icache_fetch: directed scenarios plus random traffic,
// checked against a line-level cache model and a fixed-latency pipelined memory.
module tb_icache_fetch;
  localparam int MEM_LAT = 4;
  localparam int MISS_STALL = 2 + 8 + MEM_LAT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        flush;
  logic [15:0] instr;
  logic        stall;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;

  icache_fetch dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .flush(flush), .instr(instr), .stall(stall), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Memory: pending accepted reads with their due cycle.
  logic [15:0] q_addr[$];
  int          q_due[$];
  int          cyc = 0;
  int          grants = 0;

  // Cache model: per-set valid bit and resident line address.
  logic [63:0] m_valid;
  logic [11:0] m_line [64];
  logic        busy;
  logic        done_wait;
  logic [15:0] miss_base;
  int          issued;
  int          recv;

  logic        rand_gnt = 1'b0;
  int          deny_left = 0;
  logic        last_stall;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'hA000 + {1'b0, a[15:1]};
  endfunction

  function automatic logic m_hit(input logic [15:0] a);
    return m_valid[a[9:4]] && (m_line[a[9:4]] == a[15:4]);
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    q_addr.delete();
    q_due.delete();
    m_valid   = '0;
    busy      = 1'b0;
    done_wait = 1'b0;
    issued    = 0;
    recv      = 0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then advance the model.
  task automatic step(input logic rv, input logic [15:0] ad, input logic fl);
    logic        rvld, gnt, deny, hitm, exp_stall, exp_rd, rd_s;
    logic [15:0] addr_s;
    @(negedge clk);
    rvld = (q_due.size() > 0) && (q_due[0] <= cyc);
    deny = (deny_left > 0) && busy && !done_wait && (issued == 2);
    gnt  = !deny && (!rand_gnt || ($urandom_range(0, 3) != 0));
    req_valid  = rv;
    req_addr   = ad;
    flush      = fl;
    mem_gnt    = gnt;
    mem_rvalid = rvld;
    mem_rdata  = rvld ? mem_word(q_addr[0]) : 16'h0000;
    #1;
    hitm      = m_hit(ad);
    exp_stall = busy || (rv && !hitm);
    exp_rd    = busy && !done_wait && (issued < 8);
    check_eq("stall", {15'd0, stall}, {15'd0, exp_stall});
    check_eq("mem_rd", {15'd0, mem_rd}, {15'd0, exp_rd});
    if (exp_rd) check_eq("mem_addr", mem_addr, miss_base + 16'(issued * 2));
    if (deny && exp_rd) check_eq("gnt_hold", mem_addr, miss_base + 16'h0004);
    if (rv && !exp_stall) check_eq("instr", instr, mem_word(ad));
    last_stall = stall;
    rd_s   = mem_rd;
    addr_s = mem_addr;
    @(posedge clk);
    if (rvld) begin
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end
    if (rd_s && gnt) begin
      q_addr.push_back(addr_s);
      q_due.push_back(cyc + MEM_LAT);
      grants++;
    end
    if (deny && exp_rd) deny_left--;
    if (fl) m_valid = '0;
    if (!busy) begin
      if (rv && !hitm) begin
        busy      = 1'b1;
        done_wait = 1'b0;
        miss_base = {ad[15:4], 4'h0};
        issued    = 0;
        recv      = 0;
      end
    end else if (done_wait) begin
      busy = 1'b0;
    end else begin
      if (exp_rd && gnt) issued++;
      if (rvld) begin
        recv++;
        if (recv == 8) begin
          m_valid[miss_base[9:4]] = 1'b1;
          m_line[miss_base[9:4]]  = miss_base[15:4];
          done_wait = 1'b1;
        end
      end
    end
    cyc++;
  endtask

  // Hold a fetch until it is served; reports the number of stalled cycles.
  task automatic fetch(input logic [15:0] ad, input int flush_at, output int nstall);
    nstall = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, ad, (i == flush_at));
      if (!last_stall) return;
      nstall++;
    end
    check_eq("fetch_timeout", {15'd0, last_stall}, 16'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, g0;
    model_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_addr = 16'h0000; flush = 1'b0;
    mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = 16'h0000;
    #1;
    check_eq("rst_stall", {15'd0, stall}, 16'd0);
    check_eq("rst_mem_rd", {15'd0, mem_rd}, 16'd0);
    check_eq("rst_mem_addr", mem_addr, 16'h0000);
    check_eq("rst_instr", instr, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Cold miss then hits across the line.
    fetch(16'h0000, -1, n);
    check_eq("cold_lat", 16'(n), 16'(MISS_STALL));
    for (int k = 1; k < 8; k++) step(1'b1, 16'(2 * k), 1'b0);

    // Conflict miss evicts line 0.
    fetch(16'h0400, -1, n);
    check_eq("conflict_lat", 16'(n), 16'(MISS_STALL));
    fetch(16'h0000, -1, n);
    check_eq("evict_lat", 16'(n), 16'(MISS_STALL));

    // Flush in IDLE, then refill 0x0000 with the 3rd request denied twice.
    step(1'b0, 16'h0000, 1'b1);
    deny_left = 2;
    fetch(16'h0000, -1, n);
    check_eq("backpressure_lat", 16'(n), 16'(MISS_STALL + 2));
    check_eq("deny_used", 16'(deny_left), 16'd0);
    for (int k = 1; k < 8; k++) step(1'b1, 16'(2 * k), 1'b0);

    // Flush mid-fill: the filling line survives, line 0 does not.
    fetch(16'h0010, 5, n);
    check_eq("flush_fill_lat", 16'(n), 16'(MISS_STALL));
    fetch(16'h0010, -1, n);
    check_eq("flush_fill_hit", 16'(n), 16'd0);
    fetch(16'h0000, -1, n);
    check_eq("flush_evict_lat", 16'(n), 16'(MISS_STALL));

    // Reset after three words of a fill.
    for (int i = 0; i < 40 && !(busy && recv == 3); i++) step(1'b1, 16'h0030, 1'b0);
    check_eq("rst_reach", 16'(recv), 16'd3);
    @(negedge clk);
    rst_n = 1'b0; req_valid = 1'b0; mem_rvalid = 1'b0; flush = 1'b0;
    #1;
    check_eq("midrst_stall", {15'd0, stall}, 16'd0);
    check_eq("midrst_mem_rd", {15'd0, mem_rd}, 16'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    g0 = grants;
    fetch(16'h0030, -1, n);
    check_eq("refill_lat", 16'(n), 16'(MISS_STALL));
    check_eq("refill_words", 16'(grants - g0), 16'd8);

    // Random traffic over a few conflicting lines with random grant and flush.
    rand_gnt = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] ra;
      ra = 16'(($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
      step($urandom_range(0, 3) != 0, ra, $urandom_range(0, 29) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
